// File: rtl/imem_fetch_arbiter.sv
// Shared single-port instruction store with a round-robin fetch arbiter for NUM_CORES cores.
// The loader port writes the store and blocks fetch grants in the cycle it writes.
module imem_fetch_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CORES-1:0]           REQ,
  input  logic [NUM_CORES*ADDR_W-1:0]    IMADDR,
  output logic [NUM_CORES*INSTR_W-1:0]   INSTR,
  output logic [NUM_CORES-1:0]           IVALID,
  input  logic                           LD_WR,
  input  logic [ADDR_W-1:0]              LD_ADDR,
  input  logic [INSTR_W-1:0]             LD_DATA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(NUM_CORES);

  logic [INSTR_W-1:0]           mem_q [DEPTH];
  logic [PW-1:0]                ptr_q, ptr_d;
  logic [NUM_CORES-1:0]         ivalid_q, ivalid_d;
  logic [NUM_CORES*INSTR_W-1:0] instr_q, instr_d;
  logic [NUM_CORES-1:0]         eligible;
  logic                         gnt_valid;
  logic [PW-1:0]                gnt_idx;
  logic [AW-1:0]                rd_addr;
  logic [INSTR_W-1:0]           rd_data;
  logic                         unused_addr_bits;

  // Upper address bits are deliberately ignored so addresses wrap modulo DEPTH.
  assign unused_addr_bits = ^{IMADDR, LD_ADDR};

  // A core whose response pulses this cycle is masked so its held request is not served twice.
  assign eligible = REQ & ~ivalid_q;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!LD_WR) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        idx = (int'(ptr_q) + i) % NUM_CORES;
        if (!gnt_valid && eligible[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = PW'(idx);
        end
      end
    end
  end

  assign rd_addr = IMADDR[gnt_idx*ADDR_W +: AW];
  assign rd_data = mem_q[rd_addr];

  always_comb begin
    ptr_d    = ptr_q;
    ivalid_d = '0;
    instr_d  = instr_q;
    if (gnt_valid) begin
      ptr_d             = (gnt_idx == PW'(NUM_CORES - 1)) ? '0 : gnt_idx + PW'(1);
      ivalid_d[gnt_idx] = 1'b1;
      instr_d[gnt_idx*INSTR_W +: INSTR_W] = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      ivalid_q <= '0;
      instr_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      ivalid_q <= ivalid_d;
      instr_q  <= instr_d;
    end
  end

  // Store contents survive reset.
  always_ff @(posedge clk) begin
    if (LD_WR) begin
      mem_q[LD_ADDR[AW-1:0]] <= LD_DATA;
    end
  end

  assign INSTR  = instr_q;
  assign IVALID = ivalid_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed self-checking bench for imem_fetch_arbiter: single fetch, back-to-back, loader priority,
// address wrap, round-robin order and asynchronous reset in the middle of a response.
module tb_imem_fetch_arbiter;

  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned DEPTH     = 256;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_CORES-1:0]         REQ;
  logic [NUM_CORES*ADDR_W-1:0]  IMADDR;
  logic [NUM_CORES*INSTR_W-1:0] INSTR;
  logic [NUM_CORES-1:0]         IVALID;
  logic                         LD_WR;
  logic [ADDR_W-1:0]            LD_ADDR;
  logic [INSTR_W-1:0]           LD_DATA;

  int checks = 0;
  int errors = 0;

  imem_fetch_arbiter #(
    .NUM_CORES(NUM_CORES),
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .REQ    (REQ),
    .IMADDR (IMADDR),
    .INSTR  (INSTR),
    .IVALID (IVALID),
    .LD_WR  (LD_WR),
    .LD_ADDR(LD_ADDR),
    .LD_DATA(LD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] instr_of(input int k);
    return INSTR[k*INSTR_W +: INSTR_W];
  endfunction

  task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
    IMADDR[k*ADDR_W +: ADDR_W] = a;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    LD_WR   = 1'b1;
    LD_ADDR = a;
    LD_DATA = d;
    @(negedge clk);
    LD_WR   = 1'b0;
  endtask

  initial begin
    logic [NUM_CORES-1:0] exp_v;
    rst_n   = 1'b0;
    REQ     = '0;
    IMADDR  = '0;
    LD_WR   = 1'b0;
    LD_ADDR = '0;
    LD_DATA = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ivalid", 64'(IVALID), 64'h0);
    check_eq("rst_instr", INSTR, 64'h0);
    rst_n = 1'b1;

    load(16'h0005, 16'hA1B2);
    load(16'h0010, 16'h1111);
    load(16'h0011, 16'h2222);
    load(16'h0003, 16'h0F0F);
    for (int k = 0; k < 4; k++) load(16'h0040 + 16'(k), 16'hC000 + 16'(k));
    check_eq("load_no_pulse", 64'(IVALID), 64'h0);

    // Single fetch by core 2; request still high in the pulse cycle.
    set_addr(2, 16'h0005);
    REQ = 4'b0100;
    @(negedge clk);
    check_eq("single_ivalid", 64'(IVALID), 64'h4);
    check_eq("single_instr2", 64'(instr_of(2)), 64'hA1B2);
    @(negedge clk);
    check_eq("single_no_repeat", 64'(IVALID), 64'h0);
    REQ = '0;

    // Core 1 back-to-back, new address presented in the pulse cycle.
    set_addr(1, 16'h0010);
    REQ = 4'b0010;
    @(negedge clk);
    check_eq("b2b_ivalid_a", 64'(IVALID), 64'h2);
    check_eq("b2b_instr_a", 64'(instr_of(1)), 64'h1111);
    set_addr(1, 16'h0011);
    @(negedge clk);
    check_eq("b2b_gap", 64'(IVALID), 64'h0);
    @(negedge clk);
    check_eq("b2b_ivalid_b", 64'(IVALID), 64'h2);
    check_eq("b2b_instr_b", 64'(instr_of(1)), 64'h2222);
    check_eq("hold_instr2", 64'(instr_of(2)), 64'hA1B2);
    REQ = '0;

    // Loader write collides with a core 0 fetch of the same address.
    set_addr(0, 16'h0020);
    REQ     = 4'b0001;
    LD_WR   = 1'b1;
    LD_ADDR = 16'h0020;
    LD_DATA = 16'h5555;
    @(negedge clk);
    check_eq("ld_blocks_grant", 64'(IVALID), 64'h0);
    LD_WR = 1'b0;
    @(negedge clk);
    check_eq("ld_then_ivalid", 64'(IVALID), 64'h1);
    check_eq("ld_then_instr0", 64'(instr_of(0)), 64'h5555);
    REQ = '0;

    // Address wrap modulo DEPTH.
    set_addr(3, 16'h0103);
    REQ = 4'b1000;
    @(negedge clk);
    check_eq("wrap_ivalid", 64'(IVALID), 64'h8);
    check_eq("wrap_instr3", 64'(instr_of(3)), 64'h0F0F);
    REQ = '0;
    @(negedge clk);
    check_eq("wrap_idle", 64'(IVALID), 64'h0);

    // Round-robin order from reset with all cores requesting continuously.
    rst_n = 1'b0;
    #1;
    check_eq("rr_rst_instr", INSTR, 64'h0);
    for (int k = 0; k < 4; k++) set_addr(k, 16'h0040 + 16'(k));
    @(negedge clk);
    rst_n = 1'b1;
    REQ   = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_v = 4'b0001 << (i % 4);
      check_eq($sformatf("rr_ivalid_%0d", i), 64'(IVALID), 64'(exp_v));
      check_eq($sformatf("rr_instr_%0d", i), 64'(instr_of(i % 4)), 64'hC000 + 64'(i % 4));
    end
    REQ = '0;
    @(negedge clk);
    check_eq("rr_idle", 64'(IVALID), 64'h0);

    // Asynchronous reset between the grant edge and the end of the pulse cycle.
    REQ = 4'b0100;
    @(posedge clk);
    #2;
    check_eq("mid_pre_pulse", 64'(IVALID), 64'h4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ivalid", 64'(IVALID), 64'h0);
    check_eq("mid_rst_instr", INSTR, 64'h0);
    REQ = 4'b1111;
    @(negedge clk);
    check_eq("mid_in_rst", 64'(IVALID), 64'h0);
    REQ   = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_no_stale", 64'(IVALID), 64'h0);
    REQ = 4'b1111;
    @(negedge clk);
    check_eq("mid_first_core0", 64'(IVALID), 64'h1);
    check_eq("mid_first_instr0", 64'(instr_of(0)), 64'hC000);
    REQ = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
